// File: rtl/flag_unit.sv
// flag_unit: execute-stage condition-code register, branch resolver and
// 2-deep shadow flag stack for interrupt entry / RTI.
//
// Ports:
//   i_clk, i_reset_n            clock, async active-low reset
//   i_stall                     freeze all state, suppress branch resolution
//   i_alu_zero/negative/carry   ALU flags for the instruction in execute
//   i_flag_update               load ALU Z/N
//   i_carry_update              load ALU C
//   i_setc, i_clrc              force carry to 1 / 0 (clear wins)
//   i_branch_en, i_branch_cond  jump in execute; 00 JZ, 01 JN, 10 JC, 11 JMP
//   i_int_save, i_rti_restore   push / pop the flag stack
//   o_zero/negative/carry_flag  registered flags
//   o_branch_taken              combinational jump redirect
//   o_stack_depth               shadow entries in use
//   o_stack_error               one-cycle pulse on overflow/underflow/conflict
module flag_unit #(
    parameter int STACK_DEPTH = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_stall,
    input  logic       i_alu_zero,
    input  logic       i_alu_negative,
    input  logic       i_alu_carry,
    input  logic       i_flag_update,
    input  logic       i_carry_update,
    input  logic       i_setc,
    input  logic       i_clrc,
    input  logic       i_branch_en,
    input  logic [1:0] i_branch_cond,
    input  logic       i_int_save,
    input  logic       i_rti_restore,
    output logic       o_zero_flag,
    output logic       o_negative_flag,
    output logic       o_carry_flag,
    output logic       o_branch_taken,
    output logic [1:0] o_stack_depth,
    output logic       o_stack_error
);

    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [1:0] FULL = 2'(STACK_DEPTH);

    logic          z_q, n_q, c_q;
    logic          z_d, n_d, c_d;
    logic [1:0]    depth_q, depth_d;
    logic          err_q, err_d;
    logic [2:0]    stack_q [STACK_DEPTH];

    logic          cond;
    logic          taken;
    logic          can_pop, can_push;
    logic          restore, pop, push;
    logic [AW-1:0] top_idx, push_idx;
    logic [2:0]    top_val;

    // Branch condition from registered flags only; no same-cycle forwarding.
    always_comb begin
        cond = 1'b0;
        case (i_branch_cond)
            2'b00:   cond = z_q;
            2'b01:   cond = n_q;
            2'b10:   cond = c_q;
            default: cond = 1'b1;
        endcase
    end

    assign taken = i_reset_n & i_branch_en & ~i_stall & cond;

    assign can_pop  = (depth_q != 2'd0);
    assign can_push = (depth_q != FULL);
    assign restore  = i_rti_restore & ~i_stall;
    assign pop      = restore & can_pop;
    // Restore wins a save/restore conflict, so save is dropped then.
    assign push     = i_int_save & ~i_rti_restore & ~i_stall & can_push;

    assign top_idx  = AW'(depth_q - 2'd1);
    assign push_idx = AW'(depth_q);
    assign top_val  = stack_q[top_idx];

    always_comb begin
        z_d     = z_q;
        n_d     = n_q;
        c_d     = c_q;
        depth_d = depth_q;
        err_d   = 1'b0;
        if (!i_stall) begin
            if (restore) begin
                // Underflow leaves flags untouched; every other source is
                // ignored while a restore is requested.
                if (can_pop) begin
                    {z_d, n_d, c_d} = top_val;
                end
            end else begin
                if (taken && i_branch_cond == 2'b00) begin
                    z_d = 1'b0;
                end else if (i_flag_update) begin
                    z_d = i_alu_zero;
                end

                if (taken && i_branch_cond == 2'b01) begin
                    n_d = 1'b0;
                end else if (i_flag_update) begin
                    n_d = i_alu_negative;
                end

                if (taken && i_branch_cond == 2'b10) begin
                    c_d = 1'b0;
                end else if (i_clrc) begin
                    c_d = 1'b0;
                end else if (i_setc) begin
                    c_d = 1'b1;
                end else if (i_carry_update) begin
                    c_d = i_alu_carry;
                end
            end

            if (pop) begin
                depth_d = depth_q - 2'd1;
            end else if (push) begin
                depth_d = depth_q + 2'd1;
            end

            err_d = (i_int_save & i_rti_restore)
                  | (i_rti_restore & ~can_pop)
                  | (i_int_save & ~i_rti_restore & ~can_push);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            depth_q <= 2'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= 3'b000;
            end
        end else begin
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            // Push captures the flags as they were before this edge.
            if (push) begin
                stack_q[push_idx] <= {z_q, n_q, c_q};
            end
        end
    end

    assign o_zero_flag     = z_q;
    assign o_negative_flag = n_q;
    assign o_carry_flag    = c_q;
    assign o_branch_taken  = taken;
    assign o_stack_depth   = depth_q;
    // A stalled cycle never reports an error.
    assign o_stack_error   = err_q & ~i_stall;

endmodule

// File: doc/flag_unit.md
# flag_unit

Execute-stage condition-code register and branch resolver for the pipelined RISC CPU. It consumes the zero/negative/carry flags produced by the ALU and holds them in a flag register. It resolves conditional jumps against the registered flags and clears the tested flag when a jump is taken. A 2-deep shadow stack saves flags on interrupt entry and restores them on RTI.

## Interface
- `STACK_DEPTH`, 2: number of shadow flag entries; only 2 is required.
- `i_clk` input 1: clock; all state updates on the rising edge.
- `i_reset_n` input 1: asynchronous, active-low reset.
- `i_stall` input 1: pipeline stall; freezes all state and suppresses branch resolution.
- `i_alu_zero`, `i_alu_negative`, `i_alu_carry` input 1 each: flags from the ALU for the instruction in execute.
- `i_flag_update` input 1: load ALU zero/negative flags this cycle.
- `i_carry_update` input 1: load ALU carry flag this cycle.
- `i_setc`, `i_clrc` input 1: force carry to 1 / 0.
- `i_branch_en` input 1: a jump instruction is in execute.
- `i_branch_cond` input 2: 00 JZ, 01 JN, 10 JC, 11 JMP (unconditional).
- `i_int_save` input 1: interrupt entry; push flags.
- `i_rti_restore` input 1: RTI; pop flags.
- `o_zero_flag`, `o_negative_flag`, `o_carry_flag` output 1 each: registered flags.
- `o_branch_taken` output 1: jump redirect, combinational.
- `o_stack_depth` output 2: shadow entries in use, 0..2.
- `o_stack_error` output 1: one-cycle pulse on overflow, underflow, or save/restore conflict.

## Operation
- Reset values: all flags 0, `o_stack_depth` 0, `o_stack_error` 0, both shadow entries 0. `o_branch_taken` is 0 while `i_reset_n` is low.
- Branch taken:
  - `o_branch_taken = i_branch_en & ~i_stall & cond`.
  - `cond` is Z, N or C from the *registered* flags, or 1 for JMP.
  - There is no forwarding from same-cycle ALU flags.
- Taken JZ/JN/JC clears the tested flag at the next edge. JMP clears nothing. A not-taken branch changes no flag.
- Per-flag next-value priority, highest first:
  1. Stall (hold).
  2. Restore.
  3. Branch clear.
  4. `i_clrc`.
  5. `i_setc`.
  6. ALU update.
  7. Hold.
- `i_setc` and `i_clrc` asserted together give carry 0.
- An ALU update loads only flags that are not claimed by a higher-priority source. Example: a taken JZ with `i_flag_update` gives Z=0 and N=`i_alu_negative`.
- Save:
  - Pushes the current registered {Z,N,C}, i.e. the values before this cycle's update, and depth increments.
  - Flag updates in the same cycle still apply normally.
  - Save at depth 2 is an overflow: no push, depth stays 2, `o_stack_error` pulses.
- Restore:
  - Loads the flags from the top entry, and depth decrements.
  - All other flag sources are ignored that cycle, and a taken branch's flag clear is dropped.
  - Restore at depth 0 is an underflow: flags hold, `o_stack_error` pulses.
- Save and restore asserted together: restore is performed, save is ignored, `o_stack_error` pulses.
- Stack order is LIFO: entry 1 holds the newer frame, entry 0 the older.
- `i_stall` high:
  - No flag, stack or depth change.
  - `o_stack_error` is 0.
  - `o_branch_taken` is 0.

## Timing
- Flag latency: a flag source at edge N is visible on the outputs after edge N. A branch in cycle N+1 sees it.
- `o_branch_taken` is valid in the same cycle as `i_branch_en`.
- `o_stack_error` is registered and asserted for the single cycle after the offending edge.
- Reset asserted mid-operation clears all state immediately (asynchronous). The first update occurs at the first rising edge after `i_reset_n` rises.

## Test plan
- Reset, then `i_flag_update`/`i_carry_update` with ALU Z=1, N=0, C=1 -> flags 1/0/1 next cycle. JZ that cycle -> `o_branch_taken`=1, then Z=0, N=0, C=1.
- JC with C=0 -> taken=0, flags unchanged. JMP with all flags 0 -> taken=1, flags unchanged.
- `i_setc`+`i_clrc`+`i_carry_update` (ALU C=1) -> C=0. `i_setc`+`i_carry_update` (ALU C=0) -> C=1.
- Flags 1/1/0:
  - Save -> depth 1.
  - ALU update to 0/0/1, then save -> depth 2.
  - Third save -> depth 2, error pulse.
  - Restore -> flags 0/0/1; restore -> flags 1/1/0, depth 0.
  - Restore -> error pulse, flags hold.
- Save and restore in the same cycle at depth 1 -> restore performed, depth 0, error pulse. Taken JZ with restore -> restored Z kept.
- Stall with update, save and JZ all asserted -> taken=0, no state change. Reset pulse mid-stall -> all outputs 0 without waiting for a clock edge.
